timer_counter: RTL and testbench

//   Memory-mapped programmable timer on the system bus downstream of the CPU bridge port
//   (BrAddr/BrWData/BrWE/BrRData). Counts down from a preset and raises an interrupt that
//   the system top feeds back into HWInt[2]. Two modes: one-shot (0) and auto-reload (1).

---
 rtl/timer_counter_pkg.sv | 36 +++
 rtl/timer_counter_if.sv | 21 ++
 rtl/timer_counter.sv | 127 ++++++++++++
 tb/tb_timer_counter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// ============================================================================
// Module      : timer_counter_pkg
// Description : Register map, CTRL bit positions, mode codes and FSM encoding
//               shared by the programmable down-counting timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_counter_pkg;

    localparam int c_addr_w = 2;
    localparam int c_data_w = 32;
    localparam int c_we_w   = 4;

    localparam logic [1:0] c_addr_ctrl   = 2'd0;
    localparam logic [1:0] c_addr_preset = 2'd1;
    localparam logic [1:0] c_addr_count  = 2'd2;

    localparam int c_bit_en      = 0;
    localparam int c_bit_mode_lo = 1;
    localparam int c_bit_mode_hi = 2;
    localparam int c_bit_im      = 3;

    localparam logic [1:0] c_mode_oneshot = 2'b00;
    localparam logic [1:0] c_mode_reload  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/timer_counter_if.sv
// ============================================================================
// Module      : timer_counter_if
// Description : Word-addressed register bus between the CPU bridge and timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_counter_if;
    import timer_counter_pkg::*;

    logic [c_addr_w-1:0] addr;
    logic [c_we_w-1:0]   we;
    logic [c_data_w-1:0] wdata;
    logic [c_data_w-1:0] rdata;

    modport master (output addr, we, wdata, input  rdata);
    modport slave  (input  addr, we, wdata, output rdata);

endinterface

`default_nettype wire

// File: rtl/timer_counter.sv
// ============================================================================
// Module      : timer_counter
// Description : Memory-mapped down-counting timer with one-shot and
//               auto-reload modes and a maskable interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] CTRL_WMASK = 32'h0000_000F,
    parameter logic [31:0] RST_PRESET = 32'h0000_0000
) (
    input  wire            clk,
    input  wire            reset,
    timer_counter_if.slave bus,
    output logic           irq
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;
    logic [31:0] w_ctrl_nxt;
    logic [31:0] w_preset_nxt;
    logic [31:0] w_count_nxt;
    logic        w_flag_nxt;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en;
    logic        w_reload;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        w_wr_ctrl    = (bus.addr == c_addr_ctrl)   && (bus.we != 4'b0000);
        w_wr_preset  = (bus.addr == c_addr_preset) && (bus.we != 4'b0000);
        w_en         = r_ctrl[c_bit_en];
        // Reserved mode codes 1x fall back to one-shot behaviour.
        w_reload     = (r_ctrl[c_bit_mode_hi:c_bit_mode_lo] == c_mode_reload);
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_flag_nxt   = r_irq_flag;
        w_ctrl_nxt   = r_ctrl;
        w_preset_nxt = w_wr_preset ? merge_lanes(r_preset, bus.wdata, bus.we) : r_preset;

        case (r_state)
            ST_IDLE: begin
                if (w_en) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = w_en ? ST_CNT : ST_IDLE;
            end
            ST_CNT: begin
                if (!w_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    w_count_nxt = 32'd0;
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                if (w_reload) begin
                    w_flag_nxt  = 1'b0;
                    w_state_nxt = w_en ? ST_LOAD : ST_IDLE;
                end else begin
                    w_ctrl_nxt[c_bit_en] = 1'b0;
                    w_state_nxt          = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A CPU write to CTRL overrides any hardware update in the same cycle.
        if (w_wr_ctrl) begin
            w_ctrl_nxt = merge_lanes(r_ctrl, bus.wdata, bus.we) & CTRL_WMASK;
            w_flag_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= 32'd0;
            r_preset   <= RST_PRESET;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_irq_flag <= w_flag_nxt;
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            c_addr_ctrl:   bus.rdata = r_ctrl;
            c_addr_preset: bus.rdata = r_preset;
            c_addr_count:  bus.rdata = r_count;
            default:       bus.rdata = 32'd0;
        endcase
    end

    assign irq = r_irq_flag & r_ctrl[c_bit_im];

endmodule

`default_nettype wire

// File: tb/tb_timer_counter.sv
// ============================================================================
// Module      : tb_timer_counter
// Description : Scenario-driven scoreboard bench for timer_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_counter;
    import timer_counter_pkg::*;

    localparam logic [31:0] c_tb_rst_preset = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    logic irq;

    timer_counter_if bus ();

    timer_counter #(
        .CTRL_WMASK (32'h0000_000F),
        .RST_PRESET (c_tb_rst_preset)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] count;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] w);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = w;
        tick();
        bus.we    = 4'b0000;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic step(output logic [31:0] cnt, output logic irq_s);
        tick();
        rd(c_addr_count, cnt);
        irq_s = irq;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] c, input logic i);
        exp_t e;
        e.count = c;
        e.irq   = i;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_rd [4];
        exp_rd = '{32'd0, c_tb_rst_preset, 32'd0, 32'd0};
        bus.addr = 2'd0; bus.we = 4'b0000; bus.wdata = 32'd0;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_checks++;
            if (d !== exp_rd[a]) begin
                n_fail++;
                $display("FAIL reset_rd%0d: got %h expected %h", a, d, exp_rd[a]);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_oneshot();
        exp_t e; logic [31:0] c; logic i; logic [31:0] d;
        do_reset();
        wr(c_addr_preset, 32'd3, 4'hF);
        wr(c_addr_ctrl, 32'h9, 4'hF);
        push(0, 0); push(3, 0); push(2, 0); push(1, 0); push(0, 1); push(0, 1); push(0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(c, i);
            n_checks++;
            if (c !== e.count) begin n_fail++; $display("FAIL oneshot_count: got %0d expected %0d", c, e.count); end
            n_checks++;
            if (i !== e.irq) begin n_fail++; $display("FAIL oneshot_irq: got %b expected %b", i, e.irq); end
        end
        rd(c_addr_ctrl, d);
        n_checks++;
        if (d !== 32'h8) begin n_fail++; $display("FAIL oneshot_en_clear: got %h expected 8", d); end
        wr(c_addr_ctrl, 32'h0, 4'hF);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_ack: got %b expected 0", irq); end
    endtask

    task automatic test_reload();
        exp_t e; logic [31:0] c; logic i;
        do_reset();
        wr(c_addr_preset, 32'd2, 4'hF);
        wr(c_addr_ctrl, 32'hB, 4'hF);
        push(0, 0); push(2, 0); push(1, 0); push(0, 1);
        for (int k = 0; k < 2; k++) begin
            push(0, 0); push(2, 0); push(1, 0); push(0, 1);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(c, i);
            n_checks++;
            if (c !== e.count) begin n_fail++; $display("FAIL reload_count: got %0d expected %0d", c, e.count); end
            n_checks++;
            if (i !== e.irq) begin n_fail++; $display("FAIL reload_irq: got %b expected %b", i, e.irq); end
        end
    endtask

    task automatic test_im_masked();
        exp_t e; logic [31:0] c; logic i; logic [31:0] d;
        do_reset();
        wr(c_addr_preset, 32'd1, 4'hF);
        wr(c_addr_ctrl, 32'h1, 4'hF);
        push(0, 0); push(1, 0); push(0, 0); push(0, 0); push(0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(c, i);
            n_checks++;
            if (c !== e.count) begin n_fail++; $display("FAIL masked_count: got %0d expected %0d", c, e.count); end
            n_checks++;
            if (i !== e.irq) begin n_fail++; $display("FAIL masked_irq: got %b expected %b", i, e.irq); end
        end
        wr(c_addr_ctrl, 32'h8, 4'hF);
        rd(c_addr_ctrl, d);
        n_checks++;
        if (d !== 32'h8) begin n_fail++; $display("FAIL masked_ctrl: got %h expected 8", d); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_unmask_irq: got %b expected 0", irq); end
    endtask

    task automatic test_reserved_mode();
        logic [31:0] d;
        do_reset();
        wr(c_addr_ctrl, 32'hD, 4'hF);
        for (int k = 0; k < 5; k++) tick();
        rd(c_addr_ctrl, d);
        n_checks++;
        if (d !== 32'hC) begin n_fail++; $display("FAIL reserved_ctrl: got %h expected c", d); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL reserved_irq: got %b expected 1", irq); end
    endtask

    task automatic test_pause();
        exp_t e; logic [31:0] c; logic i;
        do_reset();
        wr(c_addr_preset, 32'd10, 4'hF);
        wr(c_addr_ctrl, 32'h9, 4'hF);
        push(0, 0); push(10, 0); push(9, 0); push(8, 0); push(7, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(c, i);
            n_checks++;
            if (c !== e.count) begin n_fail++; $display("FAIL pause_run_count: got %0d expected %0d", c, e.count); end
        end
        wr(c_addr_ctrl, 32'h8, 4'hF);
        push(6, 0); push(6, 0); push(6, 0); push(6, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(c, i);
            n_checks++;
            if (c !== e.count) begin n_fail++; $display("FAIL pause_hold_count: got %0d expected %0d", c, e.count); end
            n_checks++;
            if (i !== e.irq) begin n_fail++; $display("FAIL pause_hold_irq: got %b expected %b", i, e.irq); end
        end
        wr(c_addr_ctrl, 32'h9, 4'hF);
        push(6, 0); push(10, 0); push(9, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(c, i);
            n_checks++;
            if (c !== e.count) begin n_fail++; $display("FAIL pause_resume_count: got %0d expected %0d", c, e.count); end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e; logic [31:0] c; logic i; logic [31:0] d;
        do_reset();
        wr(c_addr_preset, 32'd3, 4'hF);
        wr(c_addr_ctrl, 32'h9, 4'hF);
        push(0, 0); push(3, 0); push(2, 0); push(1, 0); push(0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(c, i);
            n_checks++;
            if (i !== e.irq) begin n_fail++; $display("FAIL simul_pre_irq: got %b expected %b", i, e.irq); end
        end
        wr(c_addr_ctrl, 32'h9, 4'hF);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL simul_flag_clear: got %b expected 0", irq); end
        rd(c_addr_ctrl, d);
        n_checks++;
        if (d !== 32'h9) begin n_fail++; $display("FAIL simul_cpu_wins: got %h expected 9", d); end
        push(0, 0); push(3, 0); push(2, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(c, i);
            n_checks++;
            if (c !== e.count) begin n_fail++; $display("FAIL simul_restart_count: got %0d expected %0d", c, e.count); end
        end
    endtask

    task automatic test_bytes_reset();
        logic [31:0] d; logic [31:0] c; logic i;
        do_reset();
        wr(c_addr_ctrl, 32'hFFFF_FFF0, 4'hF);
        rd(c_addr_ctrl, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_wmask: got %h expected 0", d); end
        wr(c_addr_preset, 32'hAABB_CCDD, 4'b0010);
        rd(c_addr_preset, d);
        n_checks++;
        if (d !== 32'h0000_CC00) begin n_fail++; $display("FAIL preset_lane: got %h expected 0000cc00", d); end
        wr(c_addr_preset, 32'd7, 4'hF);
        wr(c_addr_ctrl, 32'hFFFF_FF09, 4'b0001);
        rd(c_addr_ctrl, d);
        n_checks++;
        if (d !== 32'h9) begin n_fail++; $display("FAIL ctrl_byte: got %h expected 9", d); end
        wr(c_addr_count, 32'h1234, 4'hF);
        rd(c_addr_count, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL count_ro_idle: got %0d expected 0", d); end
        step(c, i);
        n_checks++;
        if (c !== 32'd7) begin n_fail++; $display("FAIL count_load: got %0d expected 7", c); end
        wr(c_addr_count, 32'h1234, 4'hF);
        rd(c_addr_count, d);
        n_checks++;
        if (d !== 32'd6) begin n_fail++; $display("FAIL count_ro_cnt: got %0d expected 6", d); end
        step(c, i);
        n_checks++;
        if (c !== 32'd5) begin n_fail++; $display("FAIL count_pre_reset: got %0d expected 5", c); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(c_addr_count, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_mid_count: got %0d expected 0", d); end
        rd(c_addr_ctrl, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_mid_ctrl: got %h expected 0", d); end
        rd(c_addr_preset, d);
        n_checks++;
        if (d !== c_tb_rst_preset) begin n_fail++; $display("FAIL reset_mid_preset: got %h expected %h", d, c_tb_rst_preset); end
    endtask

    initial begin
        reset     = 1'b1;
        bus.addr  = 2'd0;
        bus.we    = 4'b0000;
        bus.wdata = 32'd0;
        test_reset();
        test_oneshot();
        test_reload();
        test_im_masked();
        test_reserved_mode();
        test_pause();
        test_simultaneous();
        test_bytes_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
